// File: rtl/if_stage_pkg.sv
// Shared types and constants for the fetch (pre-IF + IF) stage.
// Holds the reset PC default, bus widths and the nextpc helper.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // {fs_pc, fs_inst} toward ID
    localparam int FS_TO_DS_BUS_WD = 64;
    // {br_taken, br_target} from ID
    localparam int BR_BUS_WD       = 33;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // Redirect wins over the sequential PC; the add wraps mod 2^32.
    function automatic logic [31:0] pc_next(
        input logic [31:0] pc,
        input br_bus_t     br
    );
        logic [31:0] seq_pc;
        seq_pc = pc + PC_STEP;
        return br.taken ? br.target : seq_pc;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle between the fetch stage, the ID stage and the inst SRAM.
// master: fetch stage side; slave: ID + SRAM (or a bench) side.
interface if_stage_if;

    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;

    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allowin,
        input  br_taken,
        input  br_target,
        input  inst_sram_rdata,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst,
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output ds_allowin,
        output br_taken,
        output br_target,
        output inst_sram_rdata,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst,
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );

endinterface

// File: rtl/if_inst_buf.sv
// Capture/hold register for the fetched instruction during a stall.
// Ports: clk, reset, capture, clear, rdata in; buf_valid, inst_buf out.
module if_inst_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] rdata,
    output logic        buf_valid,
    output logic [31:0] inst_buf
);

    logic        buf_valid_q;
    logic        buf_valid_d;
    logic [31:0] inst_buf_q;
    logic [31:0] inst_buf_d;

    // Clear has priority; capture only happens once per stall.
    always_comb begin
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (reset || clear) begin
            buf_valid_d = 1'b0;
        end else if (capture) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = rdata;
        end
    end

    always_ff @(posedge clk) begin
        buf_valid_q <= buf_valid_d;
        inst_buf_q  <= inst_buf_d;
    end

    assign buf_valid = buf_valid_q;
    assign inst_buf  = inst_buf_q;

endmodule

// File: rtl/if_stage.sv
// Pre-IF + IF stages: nextpc, inst SRAM request, PC/inst hand-off to ID.
// Ports: clk, reset (sync, active-high), bus (if_stage_if.master).
// IF_INST_BUF_EN: hold the stalled instruction in a local buffer.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    if_stage_if.master        bus
);

    logic        fs_valid_q;
    logic        fs_valid_d;
    logic [31:0] fs_pc_q;
    logic [31:0] fs_pc_d;

    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    logic [BR_BUS_WD-1:0]       br_bus;
    br_bus_t                    br;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    fs_to_ds_t                  fs_to_ds;

    assign br_bus = {bus.br_taken, bus.br_target};
    assign br     = br_bus_t'(br_bus);

    // Pre-IF
    assign to_fs_valid = ~reset;
    assign nextpc      = pc_next(fs_pc_q, br);

    // IF handshake
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid_q
                       | (fs_ready_go & bus.ds_allowin);

    always_comb begin
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        if (reset) begin
            fs_valid_d = 1'b0;
            fs_pc_d    = RESET_PC - PC_STEP;
        end else if (fs_allowin) begin
            fs_valid_d = to_fs_valid;
            fs_pc_d    = nextpc;
        end
    end

    always_ff @(posedge clk) begin
        fs_valid_q <= fs_valid_d;
        fs_pc_q    <= fs_pc_d;
    end

`ifdef IF_INST_BUF_EN
    logic        buf_capture;
    logic        buf_valid;
    logic [31:0] inst_buf;

    // Grab the SRAM word on the first stalled cycle, before
    // the SRAM is free to change its output.
    assign buf_capture = fs_valid_q & ~bus.ds_allowin & ~buf_valid;

    if_inst_buf u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .capture   (buf_capture),
        .clear     (fs_allowin),
        .rdata     (bus.inst_sram_rdata),
        .buf_valid (buf_valid),
        .inst_buf  (inst_buf)
    );

    assign fs_inst = buf_valid ? inst_buf : bus.inst_sram_rdata;
`else
    // SRAM holds its output while en=0, so it is the hold register.
    assign fs_inst = bus.inst_sram_rdata;
`endif

    assign fs_to_ds_bus = {fs_pc_q, fs_inst};
    assign fs_to_ds     = fs_to_ds_t'(fs_to_ds_bus);

    // The IF instruction is wrong-path when ID redirects.
    assign bus.fs_to_ds_valid = fs_valid_q & fs_ready_go
                              & ~bus.br_taken;
    assign bus.fs_pc          = fs_to_ds.pc;
    assign bus.fs_inst        = fs_to_ds.inst;

    assign bus.inst_sram_en    = to_fs_valid & fs_allowin;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed fetch/stall/redirect/reset.
// Monitor pops expected {pc, inst} on every accepted hand-off.
module tb_if_stage;

    logic clk;
    logic reset;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h1c00_0008) return 32'h0280_0421;
        return a ^ 32'ha5a5_0000;
    endfunction

    // Inst SRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= mem_rd(bus.inst_sram_addr);
`ifdef IF_INST_BUF_EN
        else
            bus.inst_sram_rdata <= 32'hdead_beef;
`endif
    end

    always @(posedge clk) begin
        if (!reset)
            assert (!(bus.br_taken && !bus.ds_allowin))
            else $error("illegal br_taken while ds_allowin=0");
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every instruction ID accepts.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.fs_to_ds_valid && bus.ds_allowin) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_accept: got pc %h expected none",
                         bus.fs_pc);
            end else begin
                e = exp_q.pop_front();
                chk("acc_pc", bus.fs_pc, e.pc);
                chk("acc_inst", bus.fs_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.ds_allowin = 1'b1;
        bus.br_taken   = 1'b0;
        bus.br_target  = 32'h0;

        // Reset state
        cyc(); #2;
        chk("rst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("rst_en", {31'b0, bus.inst_sram_en}, 32'd0);
        chk("rst_pc", bus.fs_pc, 32'h1bff_fffc);
        chk("rst_we", {28'b0, bus.inst_sram_we}, 32'd0);
        chk("rst_wdata", bus.inst_sram_wdata, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        #2;

        // First fetch
        chk("f0_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("f0_addr", bus.inst_sram_addr, 32'h1c00_0000);
        chk("f0_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        push(32'h1c00_0000, 32'hb9a5_0000);
        cyc(); #2;
        chk("f1_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        chk("f1_pc", bus.fs_pc, 32'h1c00_0000);
        chk("f1_addr", bus.inst_sram_addr, 32'h1c00_0004);
        push(32'h1c00_0004, 32'hb9a5_0004);
        cyc(); #2;
        push(32'h1c00_0008, 32'h0280_0421);

        // Stall 3 cycles at 0x1c000008
        cyc();
        bus.ds_allowin = 1'b0;
        #2;
        chk("st_pc", bus.fs_pc, 32'h1c00_0008);
        chk("st_inst", bus.fs_inst, 32'h0280_0421);
        chk("st_en", {31'b0, bus.inst_sram_en}, 32'd0);
        chk("st_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(); #2;
            chk("st_hold_pc", bus.fs_pc, 32'h1c00_0008);
            chk("st_hold_inst", bus.fs_inst, 32'h0280_0421);
            chk("st_hold_en", {31'b0, bus.inst_sram_en}, 32'd0);
        end
        cyc();
        bus.ds_allowin = 1'b1;
        #2;
        chk("rel_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("rel_addr", bus.inst_sram_addr, 32'h1c00_000c);
        chk("rel_inst", bus.fs_inst, 32'h0280_0421);
        push(32'h1c00_000c, 32'hb9a5_000c);
        cyc(); #2;
        chk("rel_pc", bus.fs_pc, 32'h1c00_000c);

        // Redirect at 0x1c000010
        cyc();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0100;
        #2;
        chk("br_pc", bus.fs_pc, 32'h1c00_0010);
        chk("br_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("br_addr", bus.inst_sram_addr, 32'h1c00_0100);
        chk("br_en", {31'b0, bus.inst_sram_en}, 32'd1);
        push(32'h1c00_0100, 32'hb9a5_0100);
        cyc();
        bus.br_taken = 1'b0;
        #2;
        chk("br_tgt_pc", bus.fs_pc, 32'h1c00_0100);
        chk("br_tgt_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        push(32'h1c00_0104, 32'hb9a5_0104);
        cyc(); #2;

        // Reset in the middle of a stall at 0x1c000108
        cyc();
        bus.ds_allowin = 1'b0;
        #2;
        chk("st2_en", {31'b0, bus.inst_sram_en}, 32'd0);
        cyc();
        reset = 1'b1;
        #2;
        cyc(); #2;
        chk("mrst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("mrst_en", {31'b0, bus.inst_sram_en}, 32'd0);
        chk("mrst_pc", bus.fs_pc, 32'h1bff_fffc);
        cyc();
        reset = 1'b0;
        bus.ds_allowin = 1'b1;
        #2;
        chk("refetch_addr", bus.inst_sram_addr, 32'h1c00_0000);
        chk("refetch_en", {31'b0, bus.inst_sram_en}, 32'd1);
        push(32'h1c00_0000, 32'hb9a5_0000);
        cyc(); #2;
        chk("refetch_pc", bus.fs_pc, 32'h1c00_0000);

        // Redirect into a bubble right after reset
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0200;
        #2;
        chk("bub_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("bub_addr", bus.inst_sram_addr, 32'h1c00_0200);
        chk("bub_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        push(32'h1c00_0200, 32'hb9a5_0200);
        cyc();
        bus.br_taken = 1'b0;
        #2;
        chk("bub_pc", bus.fs_pc, 32'h1c00_0200);
        chk("bub_tgt_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        cyc();
        bus.ds_allowin = 1'b0;
        #2;
        cyc(); #2;
        chk("bub_next_pc", bus.fs_pc, 32'h1c00_0204);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
